stepper_sched: RTL and testbench
================================

// Module: stepper_sched
// PURPOSE
//  Wishbone slave behind the SPI-to-wishbone command bridge that queues stepper moves and emits step/dir.
//  Each move is (interval, count, add). Step times are absolute values of the free-running 32-bit clock counter.
//  Drives the step/dir pins and contributes to the IRQ line. The shutdown input halts it.
// PARAMETERS
//  QUEUE_DEPTH       4   move FIFO entries (power of 2, 2..16)
//  STEP_PULSE_TICKS  2   clk cycles step is held high (>=1)
//  IRQ_LOW_WATER     1   IRQ when enabled and queued moves <= this
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  counter    in   32  free-running clock counter value
//  wb_stb_i   in   1   wishbone strobe
//  wb_cyc_i   in   1   wishbone cycle
//  wb_we_i    in   1   wishbone write enable
//  wb_adr_i   in   4   register address
//  wb_dat_i   in   32  write data
//  wb_dat_o   out  32  read data, valid with ack
//  wb_ack_o   out  1   one-cycle acknowledge
//  shutdown   in   1   async-sourced halt request; 2-flop synchronised internally
//  step       out  1   step pulse
//  dir        out  1   direction
//  irq        out  1   level interrupt
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, all flags 0.
//  WB: stb&cyc with ack low -> ack=1 next cycle for exactly one cycle. Ack then low >=1 cycle. Reads registered.
//  Regs: 0 STATUS/CTRL. 1 INTERVAL (latch only). 2 PUSH: [15:0] count, [31:16] add (signed); pushes {INTERVAL,count,add}.
//   3 START: absolute time T0, starts run. 4-15: read 0, writes ignored.
//  STATUS rd: [0]running [1]full [2]empty [3]shutdown_flag [4]overflow [5]dir [6]irq_en [11:8]queued moves.
//  CTRL wr: [5]dir -> dir pin next cycle. [6]irq_en. [3],[4] write-1-to-clear.
//   shutdown_flag does not clear while synced shutdown is still high.
//  PUSH when full: dropped, overflow=1. PUSH during shutdown_flag: dropped.
//  FSM: IDLE -> LOAD on START write (last_time=T0).
//   LOAD: FIFO empty -> IDLE. Else pop: next=last_time+interval. count==0 -> stay LOAD (move skipped).
//   WAIT: when $signed(counter-next)>=0 (wrap-safe): step=1, last_time=next, count--, interval+=sext(add) -> PULSE.
//   PULSE: step held STEP_PULSE_TICKS cycles. Then count!=0 -> WAIT with next=last_time+interval; count==0 -> LOAD.
//  Late events fire ASAP, never skipped. Minimum step pitch STEP_PULSE_TICKS+1 cycles.
//  All time/interval arithmetic is mod 2^32. Interval wrap is not checked.
//  START while running: ignored. PUSH and pop in the same cycle are both honoured.
//  Synced shutdown=1: next cycle step=0, FIFO flushed, state IDLE, shutdown_flag=1. This aborts a pulse mid-high.
//  irq = irq_en & (queued<=IRQ_LOW_WATER | overflow | shutdown_flag); registered.
//  rst_n low mid-move: immediate abort to reset state, step drops asynchronously.
// CONFIGURATION
//  KSTEP_BOTH_EDGE_EN defined: each event toggles step instead of pulsing (PULSE lasts 1 cycle).
//   Minimum pitch is 2 cycles. Shutdown and reset leave step at 0.
//  Undefined: pulse mode as above.
// STRUCTURE
//  Shared package kstep_pkg: register address localparams, STATUS bit indices, move_t {interval[31:0],count[15:0],add[15:0]}.
//  One sub-module: move_fifo (synchronous FIFO, push/pop/flush, full/empty/level) parameterised by QUEUE_DEPTH.
// TESTING
//  1 INTERVAL=100, PUSH count=3 add=0, START T0=1000 -> rising step edges at counter 1100, 1200, 1300. Then running=0.
//  2 PUSH (100,3,+10) then (50,1,0), START 0 -> steps at 100, 210, 330, 380. No gap between moves.
//  3 Push 5 moves into depth 4 -> 5th dropped, STATUS[4]=1, irq=1 if irq_en. Writing 0x10 to CTRL clears [4].
//  4 START T0=0xFFFFFF00, interval 0x200, counter near wrap -> step at counter 0x00000100, not immediately.
//  5 Assert shutdown mid-pulse -> step=0 within 3 cycles. FIFO empty, STATUS[3]=1, pushes ignored until cleared with shutdown low.
//  6 Assert rst_n low mid-run -> step/dir/irq/ack 0 immediately. STATUS reads 0x04 after release.

Source files
------------

// File: rtl/kstep_pkg.sv
// kstep_pkg: shared register map, STATUS bit positions, move record and FSM state type
// for the stepper move scheduler.
`default_nettype none

package kstep_pkg;

  localparam logic [3:0] ADDR_STATUS   = 4'd0;
  localparam logic [3:0] ADDR_INTERVAL = 4'd1;
  localparam logic [3:0] ADDR_PUSH     = 4'd2;
  localparam logic [3:0] ADDR_START    = 4'd3;

  localparam int ST_RUNNING    = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_EMPTY      = 2;
  localparam int ST_SHUTDOWN   = 3;
  localparam int ST_OVERFLOW   = 4;
  localparam int ST_DIR        = 5;
  localparam int ST_IRQ_EN     = 6;
  localparam int ST_QUEUED_LSB = 8;

  typedef struct packed {
    logic [31:0] interval;
    logic [15:0] count;
    logic [15:0] add;
  } move_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_PULSE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stepper_sched_move_fifo.sv
// move_fifo: synchronous move queue with push/pop/flush and occupancy level.
// DEPTH must be a power of two (2..16); flush has priority over push and pop.
`default_nettype none

module move_fifo
  import kstep_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  move_t      din,
  output move_t      dout,
  output logic       full,
  output logic       empty,
  output logic [4:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          do_push, do_pop;
  move_t         mem_q [DEPTH];

  assign full    = (level_q == 5'(DEPTH));
  assign empty   = (level_q == 5'd0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + 5'(do_push) - 5'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible through the level count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/stepper_sched.sv
// stepper_sched: Wishbone-programmed stepper move scheduler emitting step/dir at absolute counter times.
// Define KSTEP_BOTH_EDGE_EN to toggle step per event instead of emitting a pulse.
`default_nettype none

module stepper_sched
  import kstep_pkg::*;
#(
  parameter int QUEUE_DEPTH      = 4,
  parameter int STEP_PULSE_TICKS = 2,
  parameter int IRQ_LOW_WATER    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] counter,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        shutdown,
  output logic        step,
  output logic        dir,
  output logic        irq
);

`ifdef KSTEP_BOTH_EDGE_EN
  localparam int PULSE_LEN = 1;
`else
  localparam int PULSE_LEN = STEP_PULSE_TICKS;
`endif
  localparam int          PW         = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [4:0]  LOW_WATER  = 5'(IRQ_LOW_WATER);

  logic          sd_meta_q, sd_sync_q;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   interval_q, interval_d;
  logic          dir_q, dir_d;
  logic          irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;
  logic          sd_flag_q, sd_flag_d;
  logic          irq_q, irq_d;
  state_t        state_q, state_d;
  logic          step_q, step_d;
  logic [31:0]   last_time_q, last_time_d;
  logic [31:0]   next_time_q, next_time_d;
  logic [31:0]   cur_int_q, cur_int_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   add_q, add_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;

  logic        access, wr, rd;
  logic        wr_ctrl, wr_interval, wr_push, wr_start;
  logic        running, due;
  logic [31:0] delta, status;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [4:0]  fifo_level;
  move_t       fifo_din, fifo_dout;

  assign access      = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr          = access & wb_we_i;
  assign rd          = access & ~wb_we_i;
  assign wr_ctrl     = wr & (wb_adr_i == ADDR_STATUS);
  assign wr_interval = wr & (wb_adr_i == ADDR_INTERVAL);
  assign wr_push     = wr & (wb_adr_i == ADDR_PUSH);
  assign wr_start    = wr & (wb_adr_i == ADDR_START);
  assign running     = (state_q != S_IDLE);

  // Sign of the modular difference makes the due test wrap-safe.
  assign delta = counter - next_time_q;
  assign due   = ~delta[31];

  assign fifo_din  = '{interval: interval_q, count: wb_dat_i[15:0], add: wb_dat_i[31:16]};
  assign fifo_push = wr_push & ~fifo_full & ~sd_flag_q & ~sd_sync_q;

  move_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (sd_sync_q),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status                         = '0;
    status[ST_RUNNING]             = running;
    status[ST_FULL]                = fifo_full;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_SHUTDOWN]            = sd_flag_q;
    status[ST_OVERFLOW]            = ovf_q;
    status[ST_DIR]                 = dir_q;
    status[ST_IRQ_EN]              = irq_en_q;
    status[ST_QUEUED_LSB +: 4]     = fifo_level[3:0];
  end

  always_comb begin
    ack_d      = access;
    rdata_d    = '0;
    interval_d = interval_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    sd_flag_d  = sd_flag_q;
    if (rd) begin
      case (wb_adr_i)
        ADDR_STATUS:   rdata_d = status;
        ADDR_INTERVAL: rdata_d = interval_q;
        default:       rdata_d = '0;
      endcase
    end
    if (wr_interval) interval_d = wb_dat_i;
    if (wr_ctrl) begin
      dir_d    = wb_dat_i[ST_DIR];
      irq_en_d = wb_dat_i[ST_IRQ_EN];
      if (wb_dat_i[ST_OVERFLOW]) ovf_d = 1'b0;
      if (wb_dat_i[ST_SHUTDOWN] && !sd_sync_q) sd_flag_d = 1'b0;
    end
    if (wr_push && fifo_full && !sd_flag_q && !sd_sync_q) ovf_d = 1'b1;
    if (sd_sync_q) sd_flag_d = 1'b1;
    irq_d = irq_en_q & ((fifo_level <= LOW_WATER) | ovf_q | sd_flag_q);
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    last_time_d = last_time_q;
    next_time_d = next_time_q;
    cur_int_d   = cur_int_q;
    count_d     = count_q;
    add_d       = add_q;
    pulse_cnt_d = pulse_cnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          last_time_d = wb_dat_i;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
        end else begin
          fifo_pop    = 1'b1;
          next_time_d = last_time_q + fifo_dout.interval;
          cur_int_d   = fifo_dout.interval;
          count_d     = fifo_dout.count;
          add_d       = fifo_dout.add;
          state_d     = (fifo_dout.count == 16'd0) ? S_LOAD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (due) begin
`ifdef KSTEP_BOTH_EDGE_EN
          step_d = ~step_q;
`else
          step_d = 1'b1;
`endif
          last_time_d = next_time_q;
          count_d     = count_q - 16'd1;
          cur_int_d   = cur_int_q + {{16{add_q[15]}}, add_q};
          pulse_cnt_d = '0;
          state_d     = S_PULSE;
        end
      end
      S_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
`ifndef KSTEP_BOTH_EDGE_EN
          step_d = 1'b0;
`endif
          if (count_q != 16'd0) begin
            next_time_d = last_time_q + cur_int_q;
            state_d     = S_WAIT;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Shutdown overrides everything, including a pulse that is still high.
    if (sd_sync_q) begin
      state_d  = S_IDLE;
      step_d   = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_meta_q   <= 1'b0;
      sd_sync_q   <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      interval_q  <= '0;
      dir_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      sd_flag_q   <= 1'b0;
      irq_q       <= 1'b0;
      state_q     <= S_IDLE;
      step_q      <= 1'b0;
      last_time_q <= '0;
      next_time_q <= '0;
      cur_int_q   <= '0;
      count_q     <= '0;
      add_q       <= '0;
      pulse_cnt_q <= '0;
    end else begin
      sd_meta_q   <= shutdown;
      sd_sync_q   <= sd_meta_q;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      interval_q  <= interval_d;
      dir_q       <= dir_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      sd_flag_q   <= sd_flag_d;
      irq_q       <= irq_d;
      state_q     <= state_d;
      step_q      <= step_d;
      last_time_q <= last_time_d;
      next_time_q <= next_time_d;
      cur_int_q   <= cur_int_d;
      count_q     <= count_d;
      add_q       <= add_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdata_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_stepper_sched.sv
// tb_stepper_sched: scoreboard bench; expected step times are queued when moves are programmed
// and compared against the counter value at which each step rising edge is launched.
`default_nettype none

module tb_stepper_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] counter = 32'd0;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_adr_i = 4'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        shutdown = 1'b0;
  logic        step, dir, irq;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic        cnt_load = 1'b0;
  logic [31:0] cnt_val = 32'd0;
  logic        step_prev = 1'b0;

  stepper_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .counter  (counter),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .shutdown (shutdown),
    .step     (step),
    .dir      (dir),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_load) counter <= cnt_val;
    else          counter <= counter + 32'd1;
  end

  // At the negedge the counter has already advanced past the value the DUT compared.
  always @(negedge clk) begin
    if (rst_n && step && !step_prev) obs_q.push_back(counter - 32'd1);
    step_prev = step;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_counter(input logic [31:0] v);
    @(negedge clk);
    cnt_val = v;
    cnt_load = 1'b1;
    @(negedge clk);
    cnt_load = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] data);
    bit got = 0;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_dat_i = data;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; break; end
    end
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      tests++; failed++;
      $display("FAIL wb_write ack timeout adr=%0d: ack=0, required 1", adr);
    end
  endtask

  task automatic wb_read(input logic [3:0] adr, output logic [31:0] data);
    bit got = 0;
    data = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; data = wb_dat_o; break; end
    end
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    if (!got) begin
      tests++; failed++;
      $display("FAIL wb_read ack timeout adr=%0d: ack=0, required 1", adr);
    end
  endtask

  task automatic drain_scoreboard(input string name, input int budget);
    int waited = 0;
    logic [31:0] e, o;
    while (exp_q.size() > 0) begin
      if (obs_q.size() == 0) begin
        if (waited >= budget) begin
          tests++; failed++;
          $display("FAIL %s step timeout: no step seen, expected one at 0x%08h", name, exp_q[0]);
          exp_q.delete();
        end else begin
          @(posedge clk);
          waited++;
        end
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        tests++;
        if (o !== e) begin
          failed++;
          $display("FAIL %s step time: got 0x%08h, expected 0x%08h", name, o, e);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st = 32'hFFFF_FFFF;
    for (int i = 0; i < 400; i++) begin
      wb_read(4'd0, st);
      if (!st[0]) break;
    end
    tests++;
    if (st[0] !== 1'b0) begin
      failed++;
      $display("FAIL %s running never cleared: running=%0b, expected 0", name, st[0]);
    end
  endtask

  task automatic test_reset();
    logic [31:0] st;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({step, dir, irq, wb_ack_o} !== 4'b0000 || wb_dat_o !== 32'd0) begin
      failed++;
      $display("FAIL reset outputs: step/dir/irq/ack=%b dat=%h, expected 0000 and 0", {step, dir, irq, wb_ack_o}, wb_dat_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0004) begin
      failed++;
      $display("FAIL reset status: got 0x%08h, expected 0x00000004", st);
    end
  endtask

  task automatic test_single_move();
    logic [31:0] st;
    set_counter(32'd0);
    obs_q.delete();
    wb_write(4'd1, 32'd100);
    wb_write(4'd2, 32'h0000_0003);
    exp_q.push_back(32'd1100);
    exp_q.push_back(32'd1200);
    exp_q.push_back(32'd1300);
    wb_write(4'd3, 32'd1000);
    drain_scoreboard("single_move", 2000);
    wait_idle("single_move");
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0004 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL single_move end: status=0x%08h extra_steps=%0d, expected 0x00000004 and 0", st, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    set_counter(32'd0);
    obs_q.delete();
    wb_write(4'd1, 32'd100);
    wb_write(4'd2, 32'h000A_0003);
    wb_write(4'd1, 32'd50);
    wb_write(4'd2, 32'h0000_0001);
    exp_q.push_back(32'd100);
    exp_q.push_back(32'd210);
    exp_q.push_back(32'd330);
    exp_q.push_back(32'd380);
    wb_write(4'd3, 32'd0);
    drain_scoreboard("back_to_back", 1000);
    wait_idle("back_to_back");
    // Negative acceleration: 40, then 30, then 20 between steps.
    wb_write(4'd1, 32'd40);
    wb_write(4'd2, 32'hFFF6_0003);
    exp_q.push_back(32'd1040);
    exp_q.push_back(32'd1070);
    exp_q.push_back(32'd1090);
    wb_write(4'd3, 32'd1000);
    drain_scoreboard("negative_add", 1500);
    wait_idle("negative_add");
  endtask

  task automatic test_overflow();
    logic [31:0] st;
    obs_q.delete();
    wb_write(4'd0, 32'h40);
    for (int i = 0; i < 4; i++) wb_write(4'd2, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b0) begin
      failed++;
      $display("FAIL overflow irq above low water: irq=%b, expected 0", irq);
    end
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0442) begin
      failed++;
      $display("FAIL overflow full status: got 0x%08h, expected 0x00000442", st);
    end
    wb_write(4'd2, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b1) begin
      failed++;
      $display("FAIL overflow irq: irq=%b, expected 1", irq);
    end
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0452) begin
      failed++;
      $display("FAIL overflow status: got 0x%08h, expected 0x00000452", st);
    end
    wb_write(4'd0, 32'h10);
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0402) begin
      failed++;
      $display("FAIL overflow clear: got 0x%08h, expected 0x00000402", st);
    end
    // Zero-count moves are consumed without stepping.
    wb_write(4'd3, 32'd0);
    wait_idle("overflow_drain");
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0004 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL overflow drain: status=0x%08h steps=%0d, expected 0x00000004 and 0", st, obs_q.size());
    end
    wb_write(4'd0, 32'h40);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b1) begin
      failed++;
      $display("FAIL low water irq: irq=%b, expected 1", irq);
    end
    wb_write(4'd0, 32'h0);
  endtask

  task automatic test_wrap();
    set_counter(32'hFFFF_FF80);
    obs_q.delete();
    wb_write(4'd1, 32'h200);
    wb_write(4'd2, 32'h0000_0001);
    exp_q.push_back(32'h0000_0100);
    wb_write(4'd3, 32'hFFFF_FF00);
    drain_scoreboard("wrap", 800);
    wait_idle("wrap");
  endtask

  task automatic test_shutdown();
    logic [31:0] st;
    set_counter(32'd0);
    obs_q.delete();
    wb_write(4'd1, 32'd20);
    wb_write(4'd2, 32'h0000_000A);
    wb_write(4'd3, 32'd0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (step) break;
    end
    tests++;
    if (step !== 1'b1) begin
      failed++;
      $display("FAIL shutdown precondition: step=%b, expected 1", step);
    end
    shutdown = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (!step) break;
    end
    tests++;
    if (step !== 1'b0) begin
      failed++;
      $display("FAIL shutdown step drop: step=%b, expected 0", step);
    end
    repeat (60) @(posedge clk);
    tests++;
    if (obs_q.size() != 1) begin
      failed++;
      $display("FAIL shutdown halted: steps=%0d, expected 1", obs_q.size());
    end
    wb_read(4'd0, st);
    tests++;
    if ((st & 32'hF0F) !== 32'h00C) begin
      failed++;
      $display("FAIL shutdown status: got 0x%08h, expected low bits 0x00C", st);
    end
    wb_write(4'd2, 32'h0000_0001);
    wb_write(4'd0, 32'h08);
    wb_read(4'd0, st);
    tests++;
    if ((st & 32'hF0F) !== 32'h00C) begin
      failed++;
      $display("FAIL shutdown held: got 0x%08h, expected low bits 0x00C", st);
    end
    shutdown = 1'b0;
    repeat (3) @(posedge clk);
    wb_write(4'd0, 32'h08);
    wb_write(4'd2, 32'h0000_0001);
    wb_read(4'd0, st);
    tests++;
    if ((st & 32'hF0F) !== 32'h100) begin
      failed++;
      $display("FAIL shutdown cleared: got 0x%08h, expected low bits 0x100", st);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] st;
    wb_write(4'd0, 32'h60);
    tests++;
    if (dir !== 1'b1) begin
      failed++;
      $display("FAIL dir pin: dir=%b, expected 1", dir);
    end
    set_counter(32'd0);
    wb_write(4'd3, 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (step) break;
    end
    @(posedge clk); #1;
    tests++;
    if ({step, irq} !== 2'b11) begin
      failed++;
      $display("FAIL mid_run precondition: step/irq=%b, expected 11", {step, irq});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({step, dir, irq, wb_ack_o} !== 4'b0000) begin
      failed++;
      $display("FAIL async reset: step/dir/irq/ack=%b, expected 0000", {step, dir, irq, wb_ack_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(4'd0, st);
    tests++;
    if (st !== 32'h0000_0004) begin
      failed++;
      $display("FAIL reset release status: got 0x%08h, expected 0x00000004", st);
    end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_back_to_back();
    test_overflow();
    test_wrap();
    test_shutdown();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
